ch_table_selector: RTL and testbench
====================================

Name: ch_table_selector

Overview:
- Sequential, parametrised successor to the combinational cluster-head chooser in the EER-RL node datapath.
- Maintains a table of up to NUM_CH cluster-head advertisements (ID, Q-value, hop count) received over a valid/ready update port.
- Ages out stale entries on an external tick.
- On request, scans the table one entry per cycle and reports the best CH. Ranking is: minimum hops, then maximum Q, then minimum ID.
- Sits between the packet parser (CH advert decode) and the routing/Q-update logic.

Parameters:
- NUM_CH, 8, table depth (≥2).
- ID_W, 8, cluster-head ID width.
- Q_W, 16, Q-value width (unsigned).
- HOP_W, 8, hop-count width (unsigned).
- MAX_AGE, 7, age_tick count after which an un-refreshed entry is invalidated (1..15; 4-bit age counter).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- upd_valid  in  1  advert present.
- upd_ready  out  1  table accepts advert this cycle.
- upd_id  in  ID_W  advertised CH ID.
- upd_q  in  Q_W  advertised Q-value.
- upd_hops  in  HOP_W  hops to that CH.
- age_tick  in  1  one-cycle aging strobe.
- sel_start  in  1  request a selection.
- sel_busy  out  1  scan in progress.
- sel_done  out  1  one-cycle pulse, result valid.
- sel_found  out  1  at least one valid entry was seen in the scan.
- chosen_ch  out  ID_W  selected CH ID.
- chosen_q  out  Q_W  Q of selected CH.
- chosen_hops  out  HOP_W  hops of selected CH.
- table_count  out  $clog2(NUM_CH+1)  number of valid entries.
- upd_drop  out  1  pulse: new ID rejected because the table is full.

Behaviour:
- Reset (synchronous, active-high): all entries invalid, ages 0, FSM=IDLE.
  - Outputs at reset: upd_ready=1, sel_busy=0, sel_done=0, sel_found=0, upd_drop=0, table_count=0.
  - chosen_ch = all ones, chosen_q = 0, chosen_hops = all ones.
- Reset mid-scan aborts the scan; no sel_done is issued.
- FSM states: IDLE, SCAN, DONE.
  - IDLE→SCAN on sel_start.
  - SCAN→DONE after index NUM_CH-1 has been evaluated.
  - DONE→IDLE unconditionally.
  - sel_start outside IDLE is ignored; it is not queued.
- upd_ready = (state==IDLE). The table is frozen during SCAN/DONE.
- Update, accepted when upd_valid & upd_ready, takes effect next cycle:
  - ID matches a valid entry: overwrite q and hops, age←0.
  - Otherwise insert at the lowest-index invalid slot with age 0.
  - Table full and no match: no change, upd_drop=1 for one cycle.
  - Duplicate IDs never exist in the table.
- Aging:
  - A tick in IDLE increments the age of every valid entry.
  - An entry whose age equals MAX_AGE on a tick is invalidated instead of incremented.
  - Ticks arriving during SCAN/DONE set a pending flag; multiple ticks collapse to one. The pending tick is applied on the first IDLE cycle.
  - Simultaneous tick and update on the same entry: the update wins (age←0, entry stays valid).
  - A slot freed by a tick is not used by an insert in that same cycle. The insert picks from the pre-tick free set; if none exists, upd_drop.
- Scan:
  - On entry to SCAN: idx=0, have_best=0.
  - Each SCAN cycle evaluates entry idx. It becomes best if valid and (!have_best, or hops<best_hops, or hops==best_hops & q>best_q, or hops==best_hops & q==best_q & id<best_id).
  - Any valid entry qualifies, including q=0 or hops=all ones.
- Latency: sel_start sampled at cycle 0; sel_done=1 at cycle NUM_CH+1; back in IDLE (upd_ready=1) at cycle NUM_CH+2.
- Result outputs:
  - chosen_* and sel_found register at DONE and hold until the next DONE.
  - If no valid entries: sel_found=0, chosen_ch = all ones, chosen_q = 0, chosen_hops = all ones.
- table_count is updated in the same cycle as the entry valid bits.
- All arithmetic is unsigned; age saturates and never wraps.

Decomposition:
- Package ch_sel_pkg holds:
  - ch_entry_t struct {valid, id, q, hops, age}.
  - FSM state enum.
  - Function ch_better(a, b) implementing the ranking.
- One sub-module, ch_rank_cmp: combinational comparison of a candidate against the current best, shared by the scan datapath and reusable by a future parallel tree selector.

Test Plan:
- Reset, then sel_start with an empty table → sel_done at cycle 9 (NUM_CH=8), sel_found=0, chosen_ch=0xFF.
- Adverts (id,q,hops) = (5,100,2), (3,200,3), (9,150,2); sel_start → chosen_ch=9, chosen_q=150, chosen_hops=2.
- Adverts (7,150,2) then (4,150,2) → chosen_ch=4 (ID tie-break). Re-advert (7,300,2) → table_count unchanged, next scan picks 7.
- Fill 8 distinct IDs; advert with a 9th ID → upd_drop pulse, table_count=8. Re-advert an existing ID → accepted, no drop.
- MAX_AGE=7: send advert id 2, then 8 age_ticks → entry invalid, table_count=0. Advert id 2 in the same cycle as the 8th tick → entry remains valid, age 0.
- sel_start, then age_tick plus upd_valid during SCAN → upd_ready=0 (advert held by source), sel_start re-pulses ignored. Tick applied in the first IDLE cycle; a rst asserted mid-scan yields no sel_done and restores reset values.

Source files
------------

// File: rtl/ch_sel_pkg.sv
// ---------------------------------------------------------------------------
// ch_sel_pkg
// Shared types for the cluster-head table selector.
//   ch_entry_t  : one table slot (valid, id, q, hops, age)
//   sel_state_t : selector FSM states (IDLE, SCAN, DONE)
//   ch_better() : ranking rule, fewest hops, then highest Q, then lowest ID
// Field widths here set the default widths of the ch_table_selector ports.
// ---------------------------------------------------------------------------
package ch_sel_pkg;

    localparam int CH_ID_W  = 8;
    localparam int CH_Q_W   = 16;
    localparam int CH_HOP_W = 8;
    localparam int CH_AGE_W = 4;

    typedef struct packed {
        logic                valid;
        logic [CH_ID_W-1:0]  id;
        logic [CH_Q_W-1:0]   q;
        logic [CH_HOP_W-1:0] hops;
        logic [CH_AGE_W-1:0] age;
    } ch_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } sel_state_t;

    // True when a ranks strictly ahead of b. Validity is not looked at here;
    // callers decide whether either side is a live entry.
    function automatic logic ch_better(input ch_entry_t a, input ch_entry_t b);
        logic r;
        r = 1'b0;
        if (a.hops < b.hops)
            r = 1'b1;
        else if (a.hops == b.hops && a.q > b.q)
            r = 1'b1;
        else if (a.hops == b.hops && a.q == b.q && a.id < b.id)
            r = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ch_rank_cmp.sv
// ---------------------------------------------------------------------------
// ch_rank_cmp
// Combinational check of whether a candidate entry should replace the
// current best. Kept separate so a future parallel tree selector can reuse it.
// Ports:
//   cand      in  candidate table entry
//   best      in  current best entry
//   have_best in  best holds a real entry
//   better    out candidate is valid and beats (or is the first) best
// ---------------------------------------------------------------------------
module ch_rank_cmp
    import ch_sel_pkg::*;
(
    input  ch_entry_t cand,
    input  ch_entry_t best,
    input  logic      have_best,
    output logic      better
);

    // A valid candidate wins outright when nothing has been picked yet.
    assign better = cand.valid && (!have_best || ch_better(cand, best));

endmodule

// File: rtl/ch_table_selector.sv
// ---------------------------------------------------------------------------
// ch_table_selector
// Holds up to NUM_CH cluster-head adverts, ages them out on age_tick and on
// request scans the table one slot per cycle to report the best cluster head.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   upd_valid/upd_ready      advert handshake (ready only while IDLE)
//   upd_id/upd_q/upd_hops    advert contents
//   age_tick                 aging strobe (deferred while a scan runs)
//   sel_start                start a selection scan
//   sel_busy/sel_done        scan running / one-cycle result strobe
//   sel_found, chosen_*      registered result of the last scan
//   table_count              number of valid entries
//   upd_drop                 pulse when a new ID found the table full
// ---------------------------------------------------------------------------
module ch_table_selector
    import ch_sel_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int ID_W    = CH_ID_W,
    parameter int Q_W     = CH_Q_W,
    parameter int HOP_W   = CH_HOP_W,
    parameter int MAX_AGE = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [ID_W-1:0]             upd_id,
    input  logic [Q_W-1:0]              upd_q,
    input  logic [HOP_W-1:0]            upd_hops,
    input  logic                        age_tick,
    input  logic                        sel_start,
    output logic                        sel_busy,
    output logic                        sel_done,
    output logic                        sel_found,
    output logic [ID_W-1:0]             chosen_ch,
    output logic [Q_W-1:0]              chosen_q,
    output logic [HOP_W-1:0]            chosen_hops,
    output logic [$clog2(NUM_CH+1)-1:0] table_count,
    output logic                        upd_drop
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam logic [CH_AGE_W-1:0] AGE_MAX = CH_AGE_W'(MAX_AGE);

    sel_state_t       state;
    sel_state_t       state_next;
    ch_entry_t        tbl      [NUM_CH];
    ch_entry_t        tbl_next [NUM_CH];
    logic [IDX_W-1:0] idx;
    ch_entry_t        best;
    logic             have_best;
    logic             tick_pend;

    logic             accept;
    logic             tick_now;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             free_hit;
    logic [IDX_W-1:0] free_idx;
    logic [CNT_W-1:0] count_next;
    logic             drop_next;

    ch_entry_t        cand;
    logic             cand_better;
    logic             last_idx;

    // Next-state and handshake decode. Adverts are only taken in IDLE so the
    // table stays frozen while the scan walks it.
    always_comb begin
        state_next = state;
        upd_ready  = 1'b0;
        sel_busy   = 1'b0;
        sel_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                upd_ready = 1'b1;
                if (sel_start)
                    state_next = ST_SCAN;
            end
            ST_SCAN: begin
                sel_busy = 1'b1;
                if (last_idx)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                sel_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Table update. Match and free-slot search both look at the pre-tick
    // table, so a slot freed by this cycle's tick cannot be reused until the
    // next cycle. The update is applied after aging so it wins on a collision.
    always_comb begin
        accept     = upd_valid && upd_ready;
        tick_now   = upd_ready && (age_tick || tick_pend);
        match_hit  = 1'b0;
        match_idx  = '0;
        free_hit   = 1'b0;
        free_idx   = '0;
        count_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tbl[i].valid && tbl[i].id == upd_id) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!tbl[i].valid) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        drop_next = accept && !match_hit && !free_hit;
        for (int i = 0; i < NUM_CH; i++) begin
            tbl_next[i] = tbl[i];
            if (tick_now && tbl[i].valid) begin
                if (tbl[i].age == AGE_MAX)
                    tbl_next[i].valid = 1'b0;
                else
                    tbl_next[i].age = tbl[i].age + CH_AGE_W'(1);
            end
            if (accept && match_hit && match_idx == IDX_W'(i)) begin
                tbl_next[i].valid = 1'b1;
                tbl_next[i].q     = upd_q;
                tbl_next[i].hops  = upd_hops;
                tbl_next[i].age   = '0;
            end else if (accept && !match_hit && free_hit && free_idx == IDX_W'(i)) begin
                tbl_next[i].valid = 1'b1;
                tbl_next[i].id    = upd_id;
                tbl_next[i].q     = upd_q;
                tbl_next[i].hops  = upd_hops;
                tbl_next[i].age   = '0;
            end
            count_next = count_next + CNT_W'(tbl_next[i].valid);
        end
    end

    // Table, entry count, drop pulse and the deferred tick. Ticks seen while
    // busy collapse into one pending tick that the first IDLE cycle consumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++)
                tbl[i] <= '0;
            table_count <= '0;
            upd_drop    <= 1'b0;
            tick_pend   <= 1'b0;
        end else begin
            tbl         <= tbl_next;
            table_count <= count_next;
            upd_drop    <= drop_next;
            tick_pend   <= upd_ready ? 1'b0 : (tick_pend | age_tick);
        end
    end

    assign cand     = tbl[idx];
    assign last_idx = (idx == IDX_W'(NUM_CH - 1));

    ch_rank_cmp u_rank_cmp (
        .cand      (cand),
        .best      (best),
        .have_best (have_best),
        .better    (cand_better)
    );

    // Scan datapath. The last slot's comparison is folded straight into the
    // result registers so chosen_* are already valid while sel_done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            best        <= '0;
            have_best   <= 1'b0;
            sel_found   <= 1'b0;
            chosen_ch   <= '1;
            chosen_q    <= '0;
            chosen_hops <= '1;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && sel_start) begin
                idx       <= '0;
                have_best <= 1'b0;
            end else if (state == ST_SCAN) begin
                idx <= idx + IDX_W'(1);
                if (cand_better) begin
                    best      <= cand;
                    have_best <= 1'b1;
                end
                if (last_idx) begin
                    sel_found <= have_best | cand_better;
                    if (cand_better) begin
                        chosen_ch   <= cand.id;
                        chosen_q    <= cand.q;
                        chosen_hops <= cand.hops;
                    end else if (have_best) begin
                        chosen_ch   <= best.id;
                        chosen_q    <= best.q;
                        chosen_hops <= best.hops;
                    end else begin
                        chosen_ch   <= '1;
                        chosen_q    <= '0;
                        chosen_hops <= '1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ch_table_selector.sv
// ---------------------------------------------------------------------------
// tb_ch_table_selector
// Directed bench for ch_table_selector. A slot-level reference model runs
// alongside the DUT and a negedge process compares every output each cycle;
// directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ch_table_selector;

    localparam int NUM_CH  = 8;
    localparam int ID_W    = 8;
    localparam int Q_W     = 16;
    localparam int HOP_W   = 8;
    localparam int MAX_AGE = 7;
    localparam int CNT_W   = $clog2(NUM_CH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             upd_valid = 1'b0;
    logic             upd_ready;
    logic [ID_W-1:0]  upd_id = '0;
    logic [Q_W-1:0]   upd_q = '0;
    logic [HOP_W-1:0] upd_hops = '0;
    logic             age_tick = 1'b0;
    logic             sel_start = 1'b0;
    logic             sel_busy;
    logic             sel_done;
    logic             sel_found;
    logic [ID_W-1:0]  chosen_ch;
    logic [Q_W-1:0]   chosen_q;
    logic [HOP_W-1:0] chosen_hops;
    logic [CNT_W-1:0] table_count;
    logic             upd_drop;

    int checks = 0;
    int errors = 0;

    ch_table_selector #(
        .NUM_CH  (NUM_CH),
        .ID_W    (ID_W),
        .Q_W     (Q_W),
        .HOP_W   (HOP_W),
        .MAX_AGE (MAX_AGE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_id      (upd_id),
        .upd_q       (upd_q),
        .upd_hops    (upd_hops),
        .age_tick    (age_tick),
        .sel_start   (sel_start),
        .sel_busy    (sel_busy),
        .sel_done    (sel_done),
        .sel_found   (sel_found),
        .chosen_ch   (chosen_ch),
        .chosen_q    (chosen_q),
        .chosen_hops (chosen_hops),
        .table_count (table_count),
        .upd_drop    (upd_drop)
    );

    always #5 clk = ~clk;

    // Reference model: a set of slots plus a "cycles since start" counter.
    bit m_init = 0;
    bit m_valid [NUM_CH];
    int m_id    [NUM_CH];
    int m_q     [NUM_CH];
    int m_hops  [NUM_CH];
    int m_age   [NUM_CH];
    bit m_pend;
    int m_since;
    bit m_drop;
    bit snap_found;
    int snap_ch, snap_q, snap_hops;
    bit exp_found;
    int exp_ch, exp_q, exp_hops;

    task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Best = lexicographic minimum of (hops, -q, id) over valid slots.
    task automatic modelBest(output bit f, output int c, output int q, output int h);
        longint key, best_key;
        f = 0; c = (1 << ID_W) - 1; q = 0; h = (1 << HOP_W) - 1; best_key = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_valid[i]) begin
                key = (longint'(m_hops[i]) << 32) | (longint'((1 << Q_W) - 1 - m_q[i]) << 8) | longint'(m_id[i]);
                if (!f || key < best_key) begin
                    f = 1; best_key = key; c = m_id[i]; q = m_q[i]; h = m_hops[i];
                end
            end
        end
    endtask

    // Advance the model on each rising edge using the inputs the DUT sees.
    always @(posedge clk) begin
        bit idle, acc, tick;
        int mi, fi;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_valid[i] = 0; m_id[i] = 0; m_q[i] = 0; m_hops[i] = 0; m_age[i] = 0;
            end
            m_pend = 0; m_since = 0; m_drop = 0; m_init = 1;
            exp_found = 0; exp_ch = (1 << ID_W) - 1; exp_q = 0; exp_hops = (1 << HOP_W) - 1;
        end else if (m_init) begin
            idle = (m_since == 0);
            acc  = idle && upd_valid;
            tick = idle && (age_tick || m_pend);
            m_pend = idle ? 1'b0 : (m_pend || age_tick);
            mi = -1; fi = -1;
            for (int i = 0; i < NUM_CH; i++)
                if (m_valid[i] && m_id[i] == int'(upd_id)) mi = i;
            for (int i = NUM_CH - 1; i >= 0; i--)
                if (!m_valid[i]) fi = i;
            m_drop = acc && mi < 0 && fi < 0;
            if (tick)
                for (int i = 0; i < NUM_CH; i++)
                    if (m_valid[i]) begin
                        if (m_age[i] >= MAX_AGE) m_valid[i] = 0;
                        else m_age[i]++;
                    end
            if (acc && mi >= 0) begin
                m_valid[mi] = 1; m_q[mi] = upd_q; m_hops[mi] = upd_hops; m_age[mi] = 0;
            end else if (acc && fi >= 0) begin
                m_valid[fi] = 1; m_id[fi] = upd_id; m_q[fi] = upd_q; m_hops[fi] = upd_hops; m_age[fi] = 0;
            end
            if (idle && sel_start) begin
                m_since = 1;
                modelBest(snap_found, snap_ch, snap_q, snap_hops);
            end else if (m_since > 0) begin
                m_since = (m_since == NUM_CH + 1) ? 0 : m_since + 1;
                if (m_since == NUM_CH + 1) begin
                    exp_found = snap_found; exp_ch = snap_ch; exp_q = snap_q; exp_hops = snap_hops;
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        int cnt;
        if (m_init && !rst) begin
            cnt = 0;
            for (int i = 0; i < NUM_CH; i++) cnt += int'(m_valid[i]);
            checkOutput("upd_ready",   upd_ready,   m_since == 0);
            checkOutput("sel_busy",    sel_busy,    m_since >= 1 && m_since <= NUM_CH);
            checkOutput("sel_done",    sel_done,    m_since == NUM_CH + 1);
            checkOutput("upd_drop",    upd_drop,    m_drop);
            checkOutput("table_count", table_count, cnt);
            checkOutput("sel_found",   sel_found,   exp_found);
            checkOutput("chosen_ch",   chosen_ch,   exp_ch);
            checkOutput("chosen_q",    chosen_q,    exp_q);
            checkOutput("chosen_hops", chosen_hops, exp_hops);
        end
    end

    // Drive one cycle of inputs, then return just after the sampling edge.
    task automatic applyStimulus(input bit v, input int id, input int q, input int h,
                                 input bit tick, input bit start);
        upd_valid = v; upd_id = ID_W'(id); upd_q = Q_W'(q); upd_hops = HOP_W'(h);
        age_tick = tick; sel_start = start;
        @(posedge clk);
        #1;
        upd_valid = 0; age_tick = 0; sel_start = 0;
    endtask

    task automatic doReset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic advert(input int id, input int q, input int h);
        applyStimulus(1, id, q, h, 0, 0);
    endtask

    // Start a scan and return in the cycle where sel_done must be high.
    task automatic startScan();
        applyStimulus(0, 0, 0, 0, 0, 1);
        repeat (NUM_CH) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();
        checkOutput("rst upd_ready",   upd_ready,   1);
        checkOutput("rst table_count", table_count, 0);
        checkOutput("rst chosen_ch",   chosen_ch,   8'hFF);
        checkOutput("rst chosen_q",    chosen_q,    0);
        checkOutput("rst chosen_hops", chosen_hops, 8'hFF);

        // Empty table scan.
        startScan();
        checkOutput("empty sel_done",  sel_done,  1);
        checkOutput("empty sel_found", sel_found, 0);
        checkOutput("empty chosen_ch", chosen_ch, 8'hFF);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("empty back idle", upd_ready, 1);

        // Fewest hops then highest Q.
        advert(5, 100, 2); advert(3, 200, 3); advert(9, 150, 2);
        startScan();
        checkOutput("rank chosen_ch",   chosen_ch,   9);
        checkOutput("rank chosen_q",    chosen_q,    150);
        checkOutput("rank chosen_hops", chosen_hops, 2);
        checkOutput("rank sel_found",   sel_found,   1);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // ID tie-break, then refresh of an existing ID.
        doReset();
        advert(7, 150, 2); advert(4, 150, 2);
        startScan();
        checkOutput("tie chosen_ch", chosen_ch, 4);
        applyStimulus(0, 0, 0, 0, 0, 0);
        advert(7, 300, 2);
        checkOutput("refresh count", table_count, 2);
        startScan();
        checkOutput("refresh chosen_ch", chosen_ch, 7);
        checkOutput("refresh chosen_q",  chosen_q,  300);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Full table.
        doReset();
        for (int i = 0; i < NUM_CH; i++) advert(10 + i, 50 + i, 1 + i);
        checkOutput("full count", table_count, 8);
        advert(30, 1, 1);
        checkOutput("full drop",       upd_drop,    1);
        checkOutput("full drop count", table_count, 8);
        advert(12, 999, 1);
        checkOutput("full reuse drop",  upd_drop,    0);
        checkOutput("full reuse count", table_count, 8);
        startScan();
        checkOutput("full chosen_ch", chosen_ch, 12);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Aging out, and an update colliding with the expiring tick.
        doReset();
        advert(2, 1, 1);
        checkOutput("age inserted", table_count, 1);
        repeat (MAX_AGE + 1) applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("age expired", table_count, 0);
        advert(2, 1, 1);
        repeat (MAX_AGE) applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(1, 2, 1, 1, 1, 0);
        checkOutput("age update wins", table_count, 1);
        repeat (MAX_AGE) applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("age restarted", table_count, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("age expired again", table_count, 0);

        // Tick and advert during a scan, repeated starts ignored.
        doReset();
        advert(5, 10, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(1, 6, 20, 1, 1, 1);
        checkOutput("scan upd_ready", upd_ready, 0);
        repeat (NUM_CH - 1) applyStimulus(1, 6, 20, 1, 0, 1);
        checkOutput("scan sel_done",  sel_done,  1);
        checkOutput("scan chosen_ch", chosen_ch, 5);
        applyStimulus(1, 6, 20, 1, 0, 1);
        applyStimulus(1, 6, 20, 1, 0, 0);
        checkOutput("scan late advert", table_count, 2);
        checkOutput("scan no restart",  sel_busy,    0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset in the middle of a scan.
        applyStimulus(0, 0, 0, 0, 0, 1);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
        doReset();
        checkOutput("midrst sel_done",  sel_done,    0);
        checkOutput("midrst count",     table_count, 0);
        checkOutput("midrst chosen_ch", chosen_ch,   8'hFF);
        checkOutput("midrst upd_ready", upd_ready,   1);
        repeat (NUM_CH + 4) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
